dnpcie_aurora_tx_pkt_fifo: RTL

- Store-and-forward packet FIFO directly upstream of the 16-bit slave port of the Aurora TX path adapter (CRC inserter, then 16-to-32 width converter).
- Releases a packet only after its tlast word is stored, so the CRC/Aurora path never sees mid-packet bubbles.
- Drops packets that overflow the buffer or that arrive or are in flight while channel_up is low; never back-pressures the producer indefinitely.

---
 rtl/dnpcie_aurora_pkg.sv | 14 +
 rtl/dnpcie_aurora_sdp_ram.sv | 28 ++
 rtl/dnpcie_aurora_tx_pkt_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnpcie_aurora_pkg.sv
// Shared types and constants for the Aurora TX packet path.
// Holds the AXIS word width, the full-keep value and the write-FSM state enum.
package dnpcie_aurora_pkg;

    localparam int         AXIS_W     = 16;
    localparam logic [1:0] TKEEP_FULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/dnpcie_aurora_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (1-cycle latency).
module dnpcie_aurora_sdp_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dnpcie_aurora_tx_pkt_fifo.sv
// Store-and-forward packet FIFO feeding the Aurora TX adapter; drops on
// overflow or link-down instead of back-pressuring the producer.
// Ports: aclk, aresetn, channel_up, s_axis_* (16-bit in), m_axis_* (16-bit out).
// Optional macro DNPCIE_TX_FIFO_STATS_EN adds drop_pkt_count / tx_pkt_count.
module dnpcie_aurora_tx_pkt_fifo
    import dnpcie_aurora_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int MAX_PKTS_W = 6
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              channel_up,
    input  logic [AXIS_W-1:0] s_axis_tdata,
    input  logic [1:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic [1:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
`ifdef DNPCIE_TX_FIFO_STATS_EN
    output logic [15:0]       drop_pkt_count,
    output logic [15:0]       tx_pkt_count,
`endif
    input  logic              m_axis_tready
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int ENT_W = AXIS_W + 1;

    localparam logic [PTR_W-1:0]      DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0]      PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [MAX_PKTS_W-1:0] CNT_ONE = {{(MAX_PKTS_W-1){1'b0}}, 1'b1};

    wr_state_e state_q, state_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [MAX_PKTS_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic s_ready_q;

    logic [1:0]       skid_cnt_q, skid_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [ENT_W-1:0] skid0_q, skid0_d;
    logic [ENT_W-1:0] skid1_q, skid1_d;

    logic [ENT_W-1:0] ram_rdata;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] second;
    logic [1:0]       occ;

    logic s_acc;
    logic full;
    logic ovf;
    logic ram_we;
    logic commit;
    logic ren;
    logic m_valid;
    logic pop;
    logic pkt_dec;

    assign s_acc = s_axis_tvalid & s_ready_q;

    // Full is taken from registered pointers only, so a slot freed by a
    // read in this cycle cannot be reused until the next one.
    assign full = (wr_ptr_q - rd_ptr_q) == DEPTH;

    assign ovf = full
               | (s_axis_tkeep != TKEEP_FULL)
               | (s_axis_tlast & (pkt_cnt_q == '1));

    // Write FSM next-state and pointer logic.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ram_we       = 1'b0;
        commit       = 1'b0;
        if (!channel_up) begin
            wr_ptr_d = commit_ptr_q;
            unique case (state_q)
                STORE: begin
                    state_d = (s_acc && s_axis_tlast) ? IDLE : DROP;
                end
                DROP: begin
                    if (s_acc && s_axis_tlast) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE, STORE: begin
                    if (s_acc) begin
                        if (ovf) begin
                            // A tlast word closes the bad packet itself,
                            // so there is nothing left to discard.
                            wr_ptr_d = commit_ptr_q;
                            state_d  = s_axis_tlast ? IDLE : DROP;
                        end else begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (s_axis_tlast) begin
                                commit_ptr_d = wr_ptr_q + PTR_ONE;
                                commit       = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                state_d = STORE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (s_acc && s_axis_tlast) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output view: up to two skid entries followed by the RAM read register.
    assign occ     = skid_cnt_q + {1'b0, rd_pend_q};
    assign head    = (skid_cnt_q == 2'd0) ? ram_rdata : skid0_q;
    assign second  = (skid_cnt_q == 2'd1) ? ram_rdata : skid1_q;
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_axis_tready;
    assign pkt_dec = pop & head[AXIS_W];

    // Reading only while occ <= 1 keeps skid + in-flight read within two
    // entries and still sustains one word per cycle.
    assign ren = channel_up
               & (rd_ptr_q != commit_ptr_q)
               & (occ <= 2'd1);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        rd_pend_d  = rd_pend_q;
        skid_cnt_d = skid_cnt_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        if (!channel_up) begin
            rd_ptr_d   = commit_ptr_q;
            rd_pend_d  = 1'b0;
            skid_cnt_d = 2'd0;
        end else begin
            rd_ptr_d  = ren ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            rd_pend_d = ren;
            if (pop) begin
                skid0_d    = second;
                skid_cnt_d = occ - 2'd1;
            end else begin
                skid0_d    = head;
                skid1_d    = second;
                skid_cnt_d = occ;
            end
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (!channel_up) begin
            pkt_cnt_d = '0;
        end else begin
            unique case ({commit, pkt_dec})
                2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
                2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            s_ready_q    <= 1'b0;
            skid_cnt_q   <= 2'd0;
            rd_pend_q    <= 1'b0;
            skid0_q      <= '0;
            skid1_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            s_ready_q    <= 1'b1;
            skid_cnt_q   <= skid_cnt_d;
            rd_pend_q    <= rd_pend_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
        end
    end

    dnpcie_aurora_sdp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENT_W)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (ren),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid;
    // The RAM register is not reset, so data is masked while idle.
    assign m_axis_tdata  = m_valid ? head[AXIS_W-1:0] : '0;
    assign m_axis_tlast  = m_valid & head[AXIS_W];
    assign m_axis_tkeep  = TKEEP_FULL;

`ifdef DNPCIE_TX_FIFO_STATS_EN
    logic        drop_evt;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;

    // During link-down every word taken in IDLE is its own dropped packet.
    assign drop_evt = (!channel_up & s_acc & (state_q == IDLE))
                    | (!channel_up & (state_q == STORE))
                    | (channel_up & s_acc & ovf & (state_q != DROP));

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (pkt_dec && (tx_cnt_q != 16'hFFFF)) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
            tx_cnt_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign drop_pkt_count = drop_cnt_q;
    assign tx_pkt_count   = tx_cnt_q;
`endif

endmodule
